// File: rtl/taxi_eth_phy_10g_rx_reset_seq_pkg.sv
// Shared types and constants for the 10G PHY RX path.
// Carries the RX reset sequencer state type and the 64b/66b sync header codes.
package taxi_eth_phy_10g_pkg;

    typedef enum logic [1:0] {
        ASSERT   = 2'd0,
        WAIT_CDR = 2'd1,
        SETTLE   = 2'd2,
        RUN      = 2'd3
    } rx_reset_state_t;

    localparam logic [1:0] SYNC_DATA = 2'b10;
    localparam logic [1:0] SYNC_CTRL = 2'b01;

endpackage

// File: rtl/taxi_eth_phy_10g_rx_reset_seq_if.sv
// Control bundle between the RX reset sequencer and its neighbours
// (RX watchdog, management, SERDES wrapper, PCS RX).
interface taxi_eth_phy_10g_rx_reset_seq_if;

    logic       serdes_rx_reset_req;
    logic       cfg_rx_reset;
    logic       serdes_rx_cdr_lock;
    logic       serdes_rx_rst;
    logic       rx_reset_active;
    logic       rx_cdr_fail;
    logic [7:0] rx_reset_count;

    modport master (
        output serdes_rx_reset_req,
        output cfg_rx_reset,
        output serdes_rx_cdr_lock,
        input  serdes_rx_rst,
        input  rx_reset_active,
        input  rx_cdr_fail,
        input  rx_reset_count
    );

    modport slave (
        input  serdes_rx_reset_req,
        input  cfg_rx_reset,
        input  serdes_rx_cdr_lock,
        output serdes_rx_rst,
        output rx_reset_active,
        output rx_cdr_fail,
        output rx_reset_count
    );

endinterface

// File: rtl/taxi_eth_phy_10g_rx_reset_seq.sv
// 10G SERDES RX reset sequencer: pulses the SERDES RX reset, waits for a stable
// CDR lock, then releases the PCS RX path with a holdoff against repeat requests.
module taxi_eth_phy_10g_rx_reset_seq
    import taxi_eth_phy_10g_pkg::*;
#(
    parameter int RST_CYCLES     = 64,
    parameter int CDR_TIMEOUT    = 19531,
    parameter int SETTLE_CYCLES  = 1024,
    parameter int HOLDOFF_CYCLES = 19531
) (
    input  logic                          clk,
    input  logic                          rst,
    taxi_eth_phy_10g_rx_reset_seq_if.slave rx_rst_if
);

    localparam int MAX_AB  = (RST_CYCLES > CDR_TIMEOUT) ? RST_CYCLES : CDR_TIMEOUT;
    localparam int MAX_CD  = (SETTLE_CYCLES > HOLDOFF_CYCLES) ? SETTLE_CYCLES : HOLDOFF_CYCLES;
    localparam int MAX_ALL = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = ($clog2(MAX_ALL) > 0) ? $clog2(MAX_ALL) : 1;

    localparam logic [CNT_W-1:0] RST_RELOAD     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] CDR_RELOAD     = CNT_W'(CDR_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_RELOAD  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLDOFF_RELOAD = CNT_W'(HOLDOFF_CYCLES - 1);

    function automatic logic [7:0] sat_inc8(input logic [7:0] val);
        return (val == 8'hFF) ? val : val + 8'd1;
    endfunction

    rx_reset_state_t  r_state;
    rx_reset_state_t  w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_cnt_zero;
    logic             w_pulse_done;
    logic             w_fail_set;
    logic             w_fail_clr;
    logic             r_serdes_rx_rst;
    logic             r_rx_reset_active;
    logic             r_rx_cdr_fail;
    logic [7:0]       r_rx_reset_count;

    assign w_cnt_zero = (r_cnt == '0);

    // One shared down-counter; every transition reloads it for the state being entered.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_pulse_done = 1'b0;
        w_fail_set   = 1'b0;
        w_fail_clr   = 1'b0;

        if (rx_rst_if.cfg_rx_reset) begin
            w_state_nxt = ASSERT;
            w_cnt_nxt   = RST_RELOAD;
        end else begin
            case (r_state)
                ASSERT: begin
                    if (w_cnt_zero) begin
                        w_state_nxt  = WAIT_CDR;
                        w_cnt_nxt    = CDR_RELOAD;
                        w_pulse_done = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
                WAIT_CDR: begin
                    if (rx_rst_if.serdes_rx_cdr_lock) begin
                        w_state_nxt = SETTLE;
                        w_cnt_nxt   = SETTLE_RELOAD;
                    end else if (w_cnt_zero) begin
                        w_state_nxt = ASSERT;
                        w_cnt_nxt   = RST_RELOAD;
                        w_fail_set  = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
                SETTLE: begin
                    // Any dropout restarts both the lock wait and its timeout.
                    if (!rx_rst_if.serdes_rx_cdr_lock) begin
                        w_state_nxt = WAIT_CDR;
                        w_cnt_nxt   = CDR_RELOAD;
                    end else if (w_cnt_zero) begin
                        w_state_nxt = RUN;
                        w_cnt_nxt   = HOLDOFF_RELOAD;
                        w_fail_clr  = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
                RUN: begin
                    if (rx_rst_if.serdes_rx_reset_req && w_cnt_zero) begin
                        w_state_nxt = ASSERT;
                        w_cnt_nxt   = RST_RELOAD;
                    end else if (!w_cnt_zero) begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ASSERT;
                    w_cnt_nxt   = RST_RELOAD;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state           <= ASSERT;
            r_cnt             <= RST_RELOAD;
            r_serdes_rx_rst   <= 1'b1;
            r_rx_reset_active <= 1'b1;
            r_rx_cdr_fail     <= 1'b0;
            r_rx_reset_count  <= 8'd0;
        end else begin
            r_state           <= w_state_nxt;
            r_cnt             <= w_cnt_nxt;
            r_serdes_rx_rst   <= (w_state_nxt == ASSERT);
            r_rx_reset_active <= (w_state_nxt != RUN);
            if (w_fail_set) begin
                r_rx_cdr_fail <= 1'b1;
            end else if (w_fail_clr) begin
                r_rx_cdr_fail <= 1'b0;
            end
            if (w_pulse_done) begin
                r_rx_reset_count <= sat_inc8(r_rx_reset_count);
            end
        end
    end

    assign rx_rst_if.serdes_rx_rst   = r_serdes_rx_rst;
    assign rx_rst_if.rx_reset_active = r_rx_reset_active;
    assign rx_rst_if.rx_cdr_fail     = r_rx_cdr_fail;
    assign rx_rst_if.rx_reset_count  = r_rx_reset_count;

endmodule

// File: tb/tb_taxi_eth_phy_10g_rx_reset_seq.sv
// Bench for the RX reset sequencer: phase/elapsed-time reference model checked
// every cycle, directed scenarios with literal timings, then randomized traffic.
module tb_taxi_eth_phy_10g_rx_reset_seq;

    localparam int RST_CYCLES     = 4;
    localparam int CDR_TIMEOUT    = 20;
    localparam int SETTLE_CYCLES  = 8;
    localparam int HOLDOFF_CYCLES = 16;

    localparam int PH_PULSE = 0;
    localparam int PH_LOCK  = 1;
    localparam int PH_STAB  = 2;
    localparam int PH_LIVE  = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    taxi_eth_phy_10g_rx_reset_seq_if bus ();

    taxi_eth_phy_10g_rx_reset_seq #(
        .RST_CYCLES     (RST_CYCLES),
        .CDR_TIMEOUT    (CDR_TIMEOUT),
        .SETTLE_CYCLES  (SETTLE_CYCLES),
        .HOLDOFF_CYCLES (HOLDOFF_CYCLES)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .rx_rst_if (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: which phase we are in and how long we have been there.
    int m_phase   = PH_PULSE;
    int m_elapsed = 0;
    int m_count   = 0;
    int m_fail    = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_phase = PH_PULSE; m_elapsed = 0; m_count = 0; m_fail = 0;
        end else if (bus.cfg_rx_reset) begin
            m_phase = PH_PULSE; m_elapsed = 0;
        end else begin
            case (m_phase)
                PH_PULSE: if (m_elapsed == RST_CYCLES - 1) begin
                    m_phase = PH_LOCK; m_elapsed = 0;
                    m_count = (m_count < 255) ? m_count + 1 : 255;
                end else m_elapsed++;
                PH_LOCK: if (bus.serdes_rx_cdr_lock) begin
                    m_phase = PH_STAB; m_elapsed = 0;
                end else if (m_elapsed == CDR_TIMEOUT - 1) begin
                    m_phase = PH_PULSE; m_elapsed = 0; m_fail = 1;
                end else m_elapsed++;
                PH_STAB: if (!bus.serdes_rx_cdr_lock) begin
                    m_phase = PH_LOCK; m_elapsed = 0;
                end else if (m_elapsed == SETTLE_CYCLES - 1) begin
                    m_phase = PH_LIVE; m_elapsed = 0; m_fail = 0;
                end else m_elapsed++;
                default: if (bus.serdes_rx_reset_req && m_elapsed >= HOLDOFF_CYCLES - 1) begin
                    m_phase = PH_PULSE; m_elapsed = 0;
                end else if (m_elapsed < HOLDOFF_CYCLES) m_elapsed++;
            endcase
        end
    endtask

    // Every clock goes through here: advance model at the edge, compare on the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
        chk("serdes_rx_rst",   int'(bus.serdes_rx_rst),   (m_phase == PH_PULSE) ? 1 : 0);
        chk("rx_reset_active", int'(bus.rx_reset_active), (m_phase != PH_LIVE) ? 1 : 0);
        chk("rx_cdr_fail",     int'(bus.rx_cdr_fail),     m_fail);
        chk("rx_reset_count",  int'(bus.rx_reset_count),  m_count);
    endtask

    task automatic wait_active(input logic want, input int budget, output int n);
        n = 0;
        while (bus.rx_reset_active != want && n < budget) begin
            n++;
            step();
        end
        if (bus.rx_reset_active != want) chk("wait_active_timeout", 0, 1);
    endtask

    initial begin
        int n, t, c0, prev;
        int rises[$];
        int rcnt[$];

        rst = 1'b1;
        bus.serdes_rx_reset_req = 1'b0;
        bus.cfg_rx_reset        = 1'b0;
        bus.serdes_rx_cdr_lock  = 1'b1;
        repeat (3) step();
        chk("rst_serdes_rx_rst", int'(bus.serdes_rx_rst), 1);
        chk("rst_active",        int'(bus.rx_reset_active), 1);
        chk("rst_fail",          int'(bus.rx_cdr_fail), 0);
        chk("rst_count",         int'(bus.rx_reset_count), 0);

        // Power-up with lock always present.
        rst = 1'b0;
        n = 0;
        while (bus.serdes_rx_rst && n < 50) begin n++; step(); end
        chk("pwrup_pulse_len", n, 4);
        t = n;
        while (bus.rx_reset_active && t < 100) begin t++; step(); end
        chk("pwrup_active_fall", t, 13);
        chk("pwrup_count", int'(bus.rx_reset_count), 1);
        chk("pwrup_fail",  int'(bus.rx_cdr_fail), 0);

        // Request inside the holdoff is dropped; after it expires it restarts the sequence.
        repeat (3) step();
        bus.serdes_rx_reset_req = 1'b1; step(); bus.serdes_rx_reset_req = 1'b0;
        chk("holdoff_req_active", int'(bus.rx_reset_active), 0);
        chk("holdoff_req_rst",    int'(bus.serdes_rx_rst), 0);
        repeat (12) step();
        bus.serdes_rx_reset_req = 1'b1; step(); bus.serdes_rx_reset_req = 1'b0;
        chk("late_req_rst",    int'(bus.serdes_rx_rst), 1);
        chk("late_req_active", int'(bus.rx_reset_active), 1);
        chk("late_req_count",  int'(bus.rx_reset_count), 1);
        wait_active(1'b0, 100, n);

        // No lock: pulses repeat every RST_CYCLES+CDR_TIMEOUT with the count stepping.
        repeat (HOLDOFF_CYCLES) step();
        bus.serdes_rx_cdr_lock = 1'b0;
        bus.serdes_rx_reset_req = 1'b1; step(); bus.serdes_rx_reset_req = 1'b0;
        prev = int'(bus.serdes_rx_rst);
        rises.push_back(cyc); rcnt.push_back(int'(bus.rx_reset_count));
        for (int i = 0; i < 80; i++) begin
            step();
            if (bus.serdes_rx_rst && prev == 0) begin
                rises.push_back(cyc); rcnt.push_back(int'(bus.rx_reset_count));
            end
            prev = int'(bus.serdes_rx_rst);
        end
        chk("nolock_num_rises", rises.size(), 4);
        for (int i = 1; i < rises.size(); i++) begin
            chk("nolock_period", rises[i] - rises[i-1], 24);
            chk("nolock_count_step", rcnt[i] - rcnt[i-1], 1);
        end
        chk("nolock_fail", int'(bus.rx_cdr_fail), 1);

        // Lock arrives while waiting for it: one cycle to SETTLE plus the full window.
        n = 0;
        while (bus.serdes_rx_rst && n < 50) begin n++; step(); end
        repeat (2) step();
        bus.serdes_rx_cdr_lock = 1'b1;
        wait_active(1'b0, 50, t);
        chk("lock_to_run", t, 9);
        chk("lock_fail_cleared", int'(bus.rx_cdr_fail), 0);

        // One-cycle dropout at settle cycle 5 forces a fresh full window.
        repeat (HOLDOFF_CYCLES) step();
        bus.serdes_rx_cdr_lock = 1'b0;
        bus.serdes_rx_reset_req = 1'b1; step(); bus.serdes_rx_reset_req = 1'b0;
        n = 0;
        while (bus.serdes_rx_rst && n < 50) begin n++; step(); end
        bus.serdes_rx_cdr_lock = 1'b1;
        repeat (5) step();
        chk("glitch_still_active", int'(bus.rx_reset_active), 1);
        bus.serdes_rx_cdr_lock = 1'b0; step();
        bus.serdes_rx_cdr_lock = 1'b1;
        wait_active(1'b0, 50, t);
        chk("glitch_fresh_window", t, 9);

        // Management force with a concurrent watchdog request.
        c0 = int'(bus.rx_reset_count);
        bus.cfg_rx_reset = 1'b1; bus.serdes_rx_reset_req = 1'b1;
        repeat (50) step();
        chk("force_held_rst", int'(bus.serdes_rx_rst), 1);
        bus.cfg_rx_reset = 1'b0; bus.serdes_rx_reset_req = 1'b0;
        n = 0;
        while (bus.serdes_rx_rst && n < 20) begin n++; step(); end
        chk("force_tail_len", n, 4);
        chk("force_count", int'(bus.rx_reset_count), c0 + 1);
        wait_active(1'b0, 50, t);

        // Saturation of the pulse counter.
        bus.serdes_rx_cdr_lock = 1'b0;
        repeat (HOLDOFF_CYCLES) step();
        bus.serdes_rx_reset_req = 1'b1; step(); bus.serdes_rx_reset_req = 1'b0;
        repeat (300 * (RST_CYCLES + CDR_TIMEOUT)) step();
        chk("count_saturated", int'(bus.rx_reset_count), 255);

        // Mid-sequence reset clears the count and restarts.
        rst = 1'b1; step(); rst = 1'b0;
        chk("midrst_count", int'(bus.rx_reset_count), 0);
        chk("midrst_serdes_rx_rst", int'(bus.serdes_rx_rst), 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 15) == 0) bus.serdes_rx_cdr_lock = ~bus.serdes_rx_cdr_lock;
            bus.serdes_rx_reset_req = ($urandom_range(0, 7) == 0);
            if (bus.cfg_rx_reset) bus.cfg_rx_reset = ($urandom_range(0, 7) != 0);
            else                  bus.cfg_rx_reset = ($urandom_range(0, 199) == 0);
            rst = ($urandom_range(0, 999) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
